// File: rtl/mem_stage.sv
// Memory-access stage: latches the EXE->MEM bus, drives the synchronous data RAM,
// aligns/extends load data and flags misaligned accesses. Define MEM_FWD_EN for bypass outputs.
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         EXE_over,
  input  logic [159:0] EXE_MEM_bus,
  output logic         MEM_allow_in,
  input  logic         WB_allow_in,
  input  logic         cancel,
  output logic [31:0]  dm_addr,
  output logic [3:0]   dm_wen,
  output logic [31:0]  dm_wdata,
  input  logic [31:0]  dm_rdata,
  output logic         MEM_valid,
  output logic         MEM_over,
  output logic [156:0] MEM_WB_bus,
  output logic [4:0]   MEM_wdest,
  output logic [31:0]  MEM_pc
`ifdef MEM_FWD_EN
  ,
  output logic         MEM_fwd_valid,
  output logic [31:0]  MEM_fwd_data
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} ld_state_t;

  logic         valid_reg;
  logic [159:0] bus_reg;
  ld_state_t    state_reg, state_next;
  logic         held_reg;
  logic [31:0]  rdata_hold_reg;

  logic         ld, st, ld_unsigned;
  logic [1:0]   size;
  logic [31:0]  store_data, exe_result, lo_result, pc;
  logic         hi_write, lo_write, wen;
  logic [4:0]   wdest;
  logic         mfhi, mflo, mtc0, mfc0;
  logic [7:0]   cp0r_addr;
  logic         syscall, eret, brk, fetch_error, inst_reserved, overflow, delay_slot;

  assign {ld, st, size, ld_unsigned, store_data, exe_result, lo_result,
          hi_write, lo_write, wen, wdest, mfhi, mflo, mtc0, mfc0, cp0r_addr,
          syscall, eret, brk, fetch_error, inst_reserved, overflow, delay_slot,
          pc} = bus_reg;

  logic misalign, raddr_error, waddr_error, prior_exc;
  logic ld_wait, capture;

  assign misalign    = ((size == 2'b01) & exe_result[0]) |
                       ((size == 2'b10) & (exe_result[1:0] != 2'b00));
  assign raddr_error = ld & misalign;
  assign waddr_error = st & misalign;
  assign prior_exc   = fetch_error | inst_reserved | overflow | syscall | brk;

  assign MEM_over     = resetn & valid_reg & (~ld | ld_wait | raddr_error | prior_exc);
  assign MEM_allow_in = ~valid_reg | (MEM_over & WB_allow_in);
  assign MEM_valid    = valid_reg;

  always_ff @(posedge clk) begin
    if (!resetn || cancel)
      valid_reg <= 1'b0;
    else if (MEM_allow_in)
      valid_reg <= EXE_over;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      bus_reg <= '0;
    else if (EXE_over && MEM_allow_in && !cancel)
      bus_reg <= EXE_MEM_bus;
  end

  // Load FSM: a clean load spends one cycle addressing the RAM, then waits for WB.
  always_ff @(posedge clk) begin
    if (!resetn)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (valid_reg && ld && !misalign && !prior_exc && !cancel) state_next = S_WAIT;
      S_WAIT: if (cancel || WB_allow_in) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ld_wait = (state_reg == S_WAIT);
    capture = ld_wait & ~held_reg;
  end

  // RAM output is only trusted on the first WAIT cycle; later cycles use the held copy.
  always_ff @(posedge clk) begin
    if (!resetn || !ld_wait || state_next == S_IDLE)
      held_reg <= 1'b0;
    else
      held_reg <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      rdata_hold_reg <= '0;
    else if (capture)
      rdata_hold_reg <= dm_rdata;
  end

  logic [31:0] load_word, shifted, load_ext, mem_result;

  assign load_word = held_reg ? rdata_hold_reg : dm_rdata;
  assign shifted   = load_word >> {exe_result[1:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size)
      2'b00:   load_ext = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  assign mem_result = ld ? load_ext : exe_result;

  logic [3:0] lane_en;
  logic       store_fire;

  always_comb begin
    lane_en = 4'b1111;
    case (size)
      2'b00:   lane_en = 4'b0001 << exe_result[1:0];
      2'b01:   lane_en = exe_result[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Write on the leaving cycle only, so a stalled store cannot write twice.
  assign store_fire = resetn & valid_reg & st & MEM_over & WB_allow_in &
                      ~misalign & ~prior_exc & ~cancel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign dm_wen[gi] = store_fire & lane_en[gi];
      assign dm_wdata[gi*8 +: 8] = (size == 2'b00) ? store_data[7:0] :
                                   (size == 2'b01) ? store_data[(gi%2)*8 +: 8] :
                                                     store_data[gi*8 +: 8];
    end
  endgenerate

  assign dm_addr = {exe_result[31:2], 2'b00};

  assign MEM_WB_bus = {wen, wdest, mem_result, lo_result, hi_write, lo_write,
                       mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, eret, brk,
                       fetch_error, inst_reserved, raddr_error, waddr_error,
                       overflow, exe_result, delay_slot, pc};

  assign MEM_wdest = wdest & {5{valid_reg}};
  assign MEM_pc    = pc;

`ifdef MEM_FWD_EN
  assign MEM_fwd_valid = MEM_over & wen & ~mfhi & ~mflo & ~mfc0 & ~raddr_error;
  assign MEM_fwd_data  = mem_result;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed steps plus randomized traffic
// checked against a byte-level memory model.
`timescale 1ns/1ps
module tb_mem_stage;

  typedef struct packed {
    logic        ld, st;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic [31:0] store_data, exe_result, lo_result;
    logic        hi_write, lo_write, wen;
    logic [4:0]  wdest;
    logic        mfhi, mflo, mtc0, mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall, eret, brk, fetch_error, inst_reserved, overflow, delay_slot;
    logic [31:0] pc;
  } exe_bus_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] mem_result, lo_result;
    logic        hi_write, lo_write, mfhi, mflo, mtc0, mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall, eret, brk, fetch_error, inst_reserved;
    logic        raddr_error, waddr_error, overflow;
    logic [31:0] dm_addr;
    logic        delay_slot;
    logic [31:0] pc;
  } wb_bus_t;

  logic         clk = 1'b0;
  logic         resetn, EXE_over, WB_allow_in, cancel;
  logic [159:0] EXE_MEM_bus;
  logic         MEM_allow_in, MEM_valid, MEM_over;
  logic [31:0]  dm_addr, dm_wdata, dm_rdata, MEM_pc;
  logic [3:0]   dm_wen;
  logic [156:0] MEM_WB_bus;
  logic [4:0]   MEM_wdest;
`ifdef MEM_FWD_EN
  logic         MEM_fwd_valid;
  logic [31:0]  MEM_fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .EXE_over(EXE_over), .EXE_MEM_bus(EXE_MEM_bus),
    .MEM_allow_in(MEM_allow_in), .WB_allow_in(WB_allow_in), .cancel(cancel),
    .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .MEM_valid(MEM_valid), .MEM_over(MEM_over), .MEM_WB_bus(MEM_WB_bus),
    .MEM_wdest(MEM_wdest), .MEM_pc(MEM_pc)
`ifdef MEM_FWD_EN
    , .MEM_fwd_valid(MEM_fwd_valid), .MEM_fwd_data(MEM_fwd_data)
`endif
  );

  // Data RAM with registered read; noise can be muxed onto the read port.
  logic        ram_init, corrupt;
  logic [31:0] ram [0:255];
  logic [31:0] ram_q, noise;
  logic [31:0] ref_mem [0:255];

  assign dm_rdata = corrupt ? noise : ram_q;

  function automatic logic [31:0] init_word(input int i);
    if (i == 64) return 32'h8899AABB;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else begin
      ram_q <= ram[dm_addr[9:2]];
      for (int k = 0; k < 4; k++)
        if (dm_wen[k]) ram[dm_addr[9:2]][k*8 +: 8] <= dm_wdata[k*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_mis(input logic [1:0] size, input logic [31:0] a);
    return (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
  endfunction

  function automatic bit m_pexc(input exe_bus_t b);
    return b.fetch_error || b.inst_reserved || b.overflow || b.syscall || b.brk;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] size,
                                         input logic [31:0] a, input bit uns);
    int unsigned off, v;
    off = a % 4;
    if (size == 2'd0) begin
      v = (word >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = (word >> (8 * off)) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_wen(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd0) return 4'(1 << (a % 4));
    if (size == 2'd1) return (a % 4 >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return (d % 256) * 32'h01010101;
    if (size == 2'd1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [156:0] strip_result(input logic [156:0] x);
    wb_bus_t t;
    t = x;
    t.mem_result = '0;
    return t;
  endfunction

  function automatic exe_bus_t mk(input bit ld, input bit st, input logic [1:0] size,
                                  input bit uns, input logic [31:0] addr, input logic [31:0] sdata);
    exe_bus_t b;
    b = '0;
    b.ld = ld; b.st = st; b.size = size; b.ld_unsigned = uns;
    b.store_data = sdata; b.exe_result = addr;
    b.lo_result = $urandom; b.hi_write = 1'($urandom); b.lo_write = 1'($urandom);
    b.wen = ld ? 1'b1 : 1'($urandom); b.wdest = 5'($urandom);
    b.mfhi = 1'($urandom); b.mflo = 1'($urandom); b.mtc0 = 1'($urandom); b.mfc0 = 1'($urandom);
    b.cp0r_addr = 8'($urandom); b.eret = 1'($urandom); b.delay_slot = 1'($urandom);
    b.pc = $urandom & 32'hFFFFFFFC;
    return b;
  endfunction

  // One instruction through an otherwise empty stage; WB stalls 'stall' cycles once it is done.
  task automatic issue(input string tag, input exe_bus_t b, input int stall);
    bit mis, pexc, do_wr, res_ok;
    int exp_lat, last, writes, idx;
    logic [31:0] a, exp_res, seen_wdata;
    logic [3:0] seen_wen;
    logic [156:0] leave_bus;
    wb_bus_t e, got;
    a = b.exe_result;
    idx = int'((a / 4) % 256);
    mis = m_mis(b.size, a);
    pexc = m_pexc(b);
    do_wr = b.st && !mis && !pexc;
    exp_lat = (b.ld && !mis && !pexc) ? 2 : 1;
    last = exp_lat + stall;
    exp_res = b.ld ? m_load(ref_mem[idx], b.size, a, b.ld_unsigned) : a;
    res_ok = !(b.ld && (mis || pexc));
    writes = 0; seen_wen = '0; seen_wdata = '0; leave_bus = '0;

    EXE_MEM_bus = b; EXE_over = 1'b1; WB_allow_in = 1'b1;
    @(posedge clk); #1;
    EXE_over = 1'b0;
    EXE_MEM_bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int n = 1; n <= last; n++) begin
      corrupt = (n > exp_lat);
      noise = $urandom;
      WB_allow_in = !(n >= exp_lat && n < last);
      #1;
      got = MEM_WB_bus;
      check({tag, " over"}, MEM_over, n >= exp_lat);
      check({tag, " allow_in"}, MEM_allow_in, n == last);
      if (n >= exp_lat && res_ok) check({tag, " mem_result"}, got.mem_result, exp_res);
      if (dm_wen != 4'd0) begin writes++; seen_wen = dm_wen; seen_wdata = dm_wdata; end
      if (n == last) begin
        leave_bus = MEM_WB_bus;
        check({tag, " dm_addr"}, dm_addr, a & 32'hFFFFFFFC);
        check({tag, " wdest/pc"}, {MEM_wdest, MEM_pc}, {b.wdest, b.pc});
`ifdef MEM_FWD_EN
        check({tag, " fwd_valid"}, MEM_fwd_valid,
              b.wen && !b.mfhi && !b.mflo && !b.mfc0 && !(b.ld && mis));
        if (res_ok) check({tag, " fwd_data"}, MEM_fwd_data, exp_res);
`endif
      end
      @(posedge clk); #1;
    end
    corrupt = 1'b0; WB_allow_in = 1'b1;
    #1;
    check({tag, " valid_after"}, MEM_valid, 1'b0);
    check({tag, " writes"}, writes, do_wr ? 1 : 0);
    if (do_wr) check({tag, " wen/wdata"}, {seen_wen, seen_wdata}, {m_wen(b.size, a), m_wdata(b.size, b.store_data)});

    e = '0;
    e.wen = b.wen; e.wdest = b.wdest; e.lo_result = b.lo_result;
    e.hi_write = b.hi_write; e.lo_write = b.lo_write;
    e.mfhi = b.mfhi; e.mflo = b.mflo; e.mtc0 = b.mtc0; e.mfc0 = b.mfc0;
    e.cp0r_addr = b.cp0r_addr; e.syscall = b.syscall; e.eret = b.eret; e.brk = b.brk;
    e.fetch_error = b.fetch_error; e.inst_reserved = b.inst_reserved;
    e.raddr_error = b.ld && mis; e.waddr_error = b.st && mis; e.overflow = b.overflow;
    e.dm_addr = a; e.delay_slot = b.delay_slot; e.pc = b.pc;
    check({tag, " wb_bus"}, strip_result(leave_bus), e);

    if (do_wr) begin
      logic [3:0] en;
      logic [31:0] wd;
      en = m_wen(b.size, a);
      wd = m_wdata(b.size, b.store_data);
      for (int k = 0; k < 4; k++)
        if (en[k]) ref_mem[idx][k*8 +: 8] = wd[k*8 +: 8];
    end
    $display("txn %-16s ld=%0d st=%0d size=%0d addr=%08h stall=%0d exp_result=%08h", tag, b.ld, b.st, b.size, a, stall, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exe_bus_t b;
    int kind, stall;
    logic [1:0] sz;
    logic [31:0] a;

    resetn = 1'b0; EXE_over = 1'b0; EXE_MEM_bus = '0; WB_allow_in = 1'b1; cancel = 1'b0;
    corrupt = 1'b0; noise = '0; ram_init = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    ram_init = 1'b0;
    check("reset over/wen", {MEM_over, dm_wen}, 5'd0);
    check("reset outputs", {MEM_valid, dm_addr, dm_wdata, MEM_WB_bus, MEM_wdest, MEM_pc}, '0);
    check("reset allow_in", MEM_allow_in, 1'b1);
    resetn = 1'b1;
    @(posedge clk); #1;

    issue("lw_0x100", mk(1, 0, 2'd2, 0, 32'h100, 0), 0);
    issue("lb_0x103", mk(1, 0, 2'd0, 0, 32'h103, 0), 0);
    issue("lbu_0x103", mk(1, 0, 2'd0, 1, 32'h103, 0), 0);
    issue("sh_0x102", mk(0, 1, 2'd1, 0, 32'h102, 32'h1234ABCD), 0);
    issue("lw_mis_0x101", mk(1, 0, 2'd2, 0, 32'h101, 0), 0);
    issue("sw_mis_0x102", mk(0, 1, 2'd2, 0, 32'h102, 32'h55AA55AA), 0);
    issue("lw_stall3", mk(1, 0, 2'd2, 0, 32'h100, 0), 3);
    issue("lh_stall2", mk(1, 0, 2'd1, 0, 32'h102, 0), 2);
    b = mk(1, 0, 2'd2, 0, 32'h200, 0); b.overflow = 1'b1;
    issue("lw_prior_exc", b, 0);
    b = mk(0, 1, 2'd2, 0, 32'h204, 32'hDEADBEEF); b.syscall = 1'b1;
    issue("sw_prior_exc", b, 1);
    issue("alu", mk(0, 0, 2'd2, 0, $urandom, 0), 1);

    // store flushed while in MEM
    EXE_MEM_bus = mk(0, 1, 2'd2, 0, 32'h300, 32'hCAFEF00D); EXE_over = 1'b1; WB_allow_in = 1'b1;
    @(posedge clk); #1;
    EXE_over = 1'b0; cancel = 1'b1;
    #1;
    check("sw_cancel wen", dm_wen, 4'd0);
    @(posedge clk); #1;
    cancel = 1'b0;
    check("sw_cancel valid", MEM_valid, 1'b0);
    $display("txn sw_cancel addr=00000300");
    issue("lw_after_cancel", mk(1, 0, 2'd2, 0, 32'h300, 0), 0);

    // cancel together with EXE_over
    EXE_MEM_bus = mk(1, 0, 2'd2, 0, 32'h304, 0); EXE_over = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    EXE_over = 1'b0; cancel = 1'b0;
    check("cancel_accept valid", MEM_valid, 1'b0);
    $display("txn cancel_on_accept addr=00000304");

    // cancel while a load waits on WB
    EXE_MEM_bus = mk(1, 0, 2'd2, 0, 32'h304, 0); EXE_over = 1'b1;
    @(posedge clk); #1;
    EXE_over = 1'b0; WB_allow_in = 1'b0;
    @(posedge clk); #1;
    check("wait_cancel over", MEM_over, 1'b1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0; WB_allow_in = 1'b1;
    check("wait_cancel dropped", {MEM_valid, MEM_over}, 2'd0);
    $display("txn cancel_in_wait addr=00000304");
    issue("lb_after_wcancel", mk(1, 0, 2'd0, 0, 32'h305, 0), 1);

    // reset in the middle of WAIT
    b = mk(1, 0, 2'd2, 0, 32'h308, 0); b.wdest = 5'd7;
    EXE_MEM_bus = b; EXE_over = 1'b1;
    @(posedge clk); #1;
    EXE_over = 1'b0; WB_allow_in = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("mid_reset over/wen", {MEM_over, dm_wen}, 5'd0);
    @(posedge clk); #1;
    check("mid_reset outputs", {MEM_valid, MEM_over, dm_wen, dm_addr, dm_wdata, MEM_WB_bus, MEM_wdest, MEM_pc}, '0);
    check("mid_reset allow_in", MEM_allow_in, 1'b1);
    resetn = 1'b1; WB_allow_in = 1'b1;
    @(posedge clk); #1;
    $display("txn reset_in_wait addr=00000308");
    issue("lw_after_reset", mk(1, 0, 2'd2, 0, 32'h308, 0), 0);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 255)) * 4;
      if (sz == 2'd0) a = a + $urandom_range(0, 3);
      else if (sz == 2'd1) a = a + 2 * $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) a = (a & 32'hFFFFFFFC) + $urandom_range(0, 3);
      b = mk(kind == 1, kind == 2, sz, 1'($urandom), a, $urandom);
      if ($urandom_range(0, 9) == 0) b.overflow = 1'b1;
      if ($urandom_range(0, 14) == 0) b.inst_reserved = 1'b1;
      stall = $urandom_range(0, 2);
      issue("rand", b, stall);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
